ind_lamp_flasher: RTL and testbench

Lamp-driver stage downstream of the car-indicator state machine. Consumes its 2-bit indicator state (00 none, 01 right, 10 left, 11 emergency) and produces the flashing left/right lamp outputs. Adds fixed-period blinking, a minimum-flash "comfort blink", fast-flash on bulb failure and a one-cycle click pulse for the dashboard sounder.

---
 rtl/ind_lamp_flasher.sv | 135 +++++++++++++
 tb/tb_ind_lamp_flasher.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ind_lamp_flasher.sv
// ind_lamp_flasher: turns the indicator FSM's 2-bit state into flashing
// left/right lamp drives, with comfort blink, bulb-failure fast flash and a
// dashboard click pulse on every lamp turn-on.
//
// Handshake: none. ind_state is a level sampled on every clock edge; all
// outputs are registered and describe the state after that edge.
module ind_lamp_flasher #(
  parameter int HALF_PERIOD = 4,
  parameter int MIN_FLASHES = 3,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ind_state,
  input  logic       lamp_fail_l,
  input  logic       lamp_fail_r,
  output logic       lamp_l,
  output logic       lamp_r,
  output logic       click,
  output logic [3:0] flash_cnt,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RIGHT  = 2'b01,
    ST_LEFT   = 2'b10,
    ST_HAZARD = 2'b11
  } state_t;

  localparam int HP_FAST_INT = (HALF_PERIOD / 2 < 1) ? 1 : HALF_PERIOD / 2;
  localparam logic [CNT_W-1:0] HP_NORM_M1 = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HP_FAST_M1 = CNT_W'(HP_FAST_INT - 1);
  localparam logic [3:0]       MIN_F      = 4'(MIN_FLASHES);

  state_t           state, state_n;
  logic             phase_on, phase_on_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       fc_n;
  logic             comfort, comfort_n;
  logic             click_n;
  logic             lamp_l_n, lamp_r_n;
  logic [CNT_W-1:0] hp_m1;
  logic             fast;
  logic             boundary;
  state_t           req;

  // Effective half period: fast flash only on the side whose bulb has failed.
  always_comb begin
    fast  = ((state == ST_LEFT)  && lamp_fail_l) ||
            ((state == ST_RIGHT) && lamp_fail_r);
    hp_m1 = fast ? HP_FAST_M1 : HP_NORM_M1;
  end

  // Next-state logic: mode entry/change, phase sequencing, comfort blink.
  always_comb begin
    req        = state_t'(ind_state);
    boundary   = (cnt >= hp_m1);
    state_n    = state;
    phase_on_n = phase_on;
    cnt_n      = cnt;
    fc_n       = flash_cnt;
    comfort_n  = comfort;
    click_n    = 1'b0;

    if ((req != ST_IDLE) && (req != state)) begin
      // Entry from IDLE or a switch between non-zero modes: restart at ON.
      state_n    = req;
      phase_on_n = 1'b1;
      cnt_n      = '0;
      fc_n       = 4'd1;
      comfort_n  = 1'b0;
      click_n    = 1'b1;
    end else if (state == ST_IDLE) begin
      // Stay idle; counters already cleared.
    end else if ((req == ST_IDLE) &&
                 ((state == ST_HAZARD) || (!comfort && flash_cnt >= MIN_F))) begin
      state_n    = ST_IDLE;
      phase_on_n = 1'b0;
      cnt_n      = '0;
      fc_n       = 4'd0;
      comfort_n  = 1'b0;
    end else begin
      // Continue blinking; released indicator with too few flashes enters
      // comfort blink, same-side request cancels it.
      comfort_n = (req == ST_IDLE);
      if (!boundary) begin
        cnt_n = cnt + 1'b1;
      end else if (phase_on) begin
        phase_on_n = 1'b0;
        cnt_n      = '0;
      end else if (comfort_n && (flash_cnt >= MIN_F)) begin
        state_n    = ST_IDLE;
        phase_on_n = 1'b0;
        cnt_n      = '0;
        fc_n       = 4'd0;
        comfort_n  = 1'b0;
      end else begin
        phase_on_n = 1'b1;
        cnt_n      = '0;
        fc_n       = (flash_cnt == 4'd15) ? 4'd15 : flash_cnt + 4'd1;
        click_n    = 1'b1;
      end
    end

    lamp_l_n = phase_on_n && ((state_n == ST_LEFT)  || (state_n == ST_HAZARD));
    lamp_r_n = phase_on_n && ((state_n == ST_RIGHT) || (state_n == ST_HAZARD));
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase_on  <= 1'b0;
      cnt       <= '0;
      comfort   <= 1'b0;
      flash_cnt <= 4'd0;
      click     <= 1'b0;
      lamp_l    <= 1'b0;
      lamp_r    <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_n;
      phase_on  <= phase_on_n;
      cnt       <= cnt_n;
      comfort   <= comfort_n;
      flash_cnt <= fc_n;
      click     <= click_n;
      lamp_l    <= lamp_l_n;
      lamp_r    <= lamp_r_n;
      active    <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ind_lamp_flasher.sv
// Testbench for ind_lamp_flasher: directed vectors; each drive pushes the
// expected post-edge outputs, a negedge monitor pops and compares.
module tb_ind_lamp_flasher;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ind_state;
  logic       lamp_fail_l;
  logic       lamp_fail_r;
  logic       lamp_l;
  logic       lamp_r;
  logic       click;
  logic [3:0] flash_cnt;
  logic       active;

  int checks   = 0;
  int failures = 0;

  // expected vector: {lamp_l, lamp_r, click, flash_cnt[3:0], active}
  logic [7:0] exp_q[$];
  string      name_q[$];

  ind_lamp_flasher #(
    .HALF_PERIOD(4),
    .MIN_FLASHES(3),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ind_state(ind_state),
    .lamp_fail_l(lamp_fail_l),
    .lamp_fail_r(lamp_fail_r),
    .lamp_l(lamp_l),
    .lamp_r(lamp_r),
    .click(click),
    .flash_cnt(flash_cnt),
    .active(active)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [7:0] e;
    logic [7:0] got;
    string      n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      got = {lamp_l, lamp_r, click, flash_cnt, active};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got l=%b r=%b click=%b cnt=%0d act=%b, expected l=%b r=%b click=%b cnt=%0d act=%b",
                 n, got[7], got[6], got[5], got[4:1], got[0],
                 e[7], e[6], e[5], e[4:1], e[0]);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic rst, input logic [1:0] ind, input logic fl,
                       input logic fr, input logic [7:0] e, input string n);
    reset       = rst;
    ind_state   = ind;
    lamp_fail_l = fl;
    lamp_fail_r = fr;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n, input string name);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, name);
  endtask

  // Cycles i0..i1-1 of a blink sequence that began at cycle 0 in mode `ind`.
  // Expected pattern is the lamp/click/count sequence for the given period.
  task automatic blink(input logic [1:0] ind, input logic fl, input logic fr,
                       input logic wl, input logic wr, input int period,
                       input int i0, input int i1, input string name);
    for (int i = i0; i < i1; i++) begin
      logic       on;
      logic [3:0] fc;
      int         f;
      on = (i % period) < (period / 2);
      f  = i / period + 1;
      fc = (f > 15) ? 4'd15 : 4'(f);
      drive(1'b0, ind, fl, fr, {on & wl, on & wr, (i % period) == 0, fc, 1'b1}, name);
    end
  endtask

  initial begin
    // reset and idle
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, "reset");
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, "reset");
    idle_steps(20, "idle");

    // left blink, then release with 3 flashes done: idle at next edge
    blink(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 8, 0, 24, "left_blink");
    idle_steps(4, "left_release");

    // comfort blink: right for 2 cycles then released
    blink(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8, 0, 2, "comfort_hold");
    blink(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8, 2, 24, "comfort_blink");
    idle_steps(4, "comfort_end");

    // fast flash on left bulb failure
    blink(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0, 12, "fast_left");
    idle_steps(2, "fast_release");
    // right bulb failure does not affect left
    blink(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8, 0, 24, "left_fail_r");
    idle_steps(2, "left_fail_r_release");

    // hazard override after 5 cycles of left, then release at once
    blink(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 8, 0, 5, "pre_hazard");
    blink(2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8, 0, 10, "hazard");
    idle_steps(3, "hazard_release");

    // reset mid operation with flash_cnt=2, then re-entry
    blink(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8, 0, 10, "right_pre_reset");
    drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, "mid_reset");
    blink(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8, 0, 17, "right_reentry");
    idle_steps(2, "right_release");

    // flash_cnt saturation at 15 with blinking continuing
    blink(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 8, 0, 136, "saturate");
    idle_steps(2, "saturate_release");

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
